// File: rtl/uart_rx_var_br.sv
// Variable-baud 8N1 UART receiver. The baud divisor is picked from a 3-bit table,
// latched at each start edge, and held for the whole frame.
module uart_rx_var_br #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Rx,
  input  logic [2:0]           BR_Select,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic                 Frame_Error,
  output logic                 Busy,
  output logic [14:0]          Rx_r_BR_Clocks,
  output logic [2:0]           o_dbg_state
);

  localparam int CW = 15;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam int DIV_0 = CLK_FREQ_HZ / 9600;
  localparam int DIV_1 = CLK_FREQ_HZ / 19200;
  localparam int DIV_2 = CLK_FREQ_HZ / 38400;
  localparam int DIV_3 = CLK_FREQ_HZ / 57600;
  localparam int DIV_4 = CLK_FREQ_HZ / 115200;
  localparam int DIV_5 = CLK_FREQ_HZ / 230400;
  localparam int DIV_6 = CLK_FREQ_HZ / 460800;
  localparam int DIV_7 = CLK_FREQ_HZ / 921600;

  // The slowest rate must fit the 15-bit counter; the fastest needs a usable half period.
  if (DIV_0 > 32767 || DIV_7 < 2) begin : g_div_check
    $error("uart_rx_var_br: baud divisor table out of range for CLK_FREQ_HZ");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_rx_meta;
  logic                  r_rx_sync;
  logic                  r_rx_prev;
  logic [CW-1:0]         r_clk_count;
  logic [IW-1:0]         r_bit_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_busy;
  logic [CW-1:0]         r_br_clocks;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic [IW-1:0]         w_bit_nxt;
  logic [DATA_BITS-1:0]  w_shift_nxt;
  logic [DATA_BITS-1:0]  w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_ferr_nxt;
  logic                  w_busy_nxt;
  logic [CW-1:0]         w_br_nxt;
  logic [CW-1:0]         w_div;
  logic [CW-1:0]         w_half_last;
  logic [CW-1:0]         w_full_last;
  logic                  w_fall;

  always_comb begin
    w_div = CW'(DIV_0);
    case (BR_Select)
      3'd0: w_div = CW'(DIV_0);
      3'd1: w_div = CW'(DIV_1);
      3'd2: w_div = CW'(DIV_2);
      3'd3: w_div = CW'(DIV_3);
      3'd4: w_div = CW'(DIV_4);
      3'd5: w_div = CW'(DIV_5);
      3'd6: w_div = CW'(DIV_6);
      3'd7: w_div = CW'(DIV_7);
      default: w_div = CW'(DIV_0);
    endcase
  end

  assign w_half_last = (r_br_clocks >> 1) - CW'(1);
  assign w_full_last = r_br_clocks - CW'(1);
  assign w_fall      = r_rx_prev & ~r_rx_sync;

  // Valid/ready handshake does not exist here: Rx_Valid and Frame_Error are
  // single-cycle pulses and the consumer must capture Rx_Data on Rx_Valid.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_clk_count + CW'(1);
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_br_nxt    = r_br_clocks;
    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        if (w_fall) begin
          w_br_nxt    = w_div;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_clk_count == w_half_last) begin
          w_count_nxt = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_clk_count == w_full_last) begin
          w_count_nxt            = '0;
          w_shift_nxt[r_bit_idx] = r_rx_sync;
          if (r_bit_idx == IW'(DATA_BITS - 1)) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_idx + IW'(1);
          end
        end
      end
      S_STOP: begin
        if (r_clk_count == w_full_last) begin
          w_count_nxt = '0;
          if (r_rx_sync) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_count_nxt = '0;
        if (r_rx_sync) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_clk_count <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_busy      <= 1'b0;
      r_br_clocks <= '0;
    end else begin
      r_rx_meta   <= Rx;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_state     <= w_state_nxt;
      r_clk_count <= w_count_nxt;
      r_bit_idx   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_ferr      <= w_ferr_nxt;
      r_busy      <= w_busy_nxt;
      r_br_clocks <= w_br_nxt;
    end
  end

  assign Rx_Data        = r_data;
  assign Rx_Valid       = r_valid;
  assign Frame_Error    = r_ferr;
  assign Busy           = r_busy;
  assign Rx_r_BR_Clocks = r_br_clocks;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_uart_rx_var_br.sv
// Bench for uart_rx_var_br: a serial-line driver plays the transmitter, a negedge
// monitor records pulses, and each scenario task checks against a baud/byte model.
module tb_uart_rx_var_br;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx, rx2;
  logic [2:0]  sel, sel2;
  logic [7:0]  rx_data, rx_data2;
  logic        rx_valid, rx_valid2;
  logic        frame_err, frame_err2;
  logic        busy, busy2;
  logic [14:0] br_clk, br_clk2;
  logic [2:0]  dbg_state, dbg_state2;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor-owned counters and capture queues; tasks only read them.
  int cyc = 0;
  int valid_cyc = 0;
  int n_valid = 0, n_ferr = 0, n_both = 0, busy_cyc = 0;
  int n_valid2 = 0, n_ferr2 = 0, n_both2 = 0;
  logic [7:0] got_q[$];
  logic [7:0] got2_q[$];

  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  always #5 clk = ~clk;

  uart_rx_var_br #(.CLK_FREQ_HZ(100_000_000), .DATA_BITS(8)) dut (
    .clk(clk), .Reset(rst), .Rx(rx), .BR_Select(sel),
    .Rx_Data(rx_data), .Rx_Valid(rx_valid), .Frame_Error(frame_err),
    .Busy(busy), .Rx_r_BR_Clocks(br_clk), .o_dbg_state(dbg_state)
  );

  // Slower-clocked copy so the loopback sweep covers every select in a short run.
  uart_rx_var_br #(.CLK_FREQ_HZ(4_000_000), .DATA_BITS(8)) dut_lb (
    .clk(clk), .Reset(rst), .Rx(rx2), .BR_Select(sel2),
    .Rx_Data(rx_data2), .Rx_Valid(rx_valid2), .Frame_Error(frame_err2),
    .Busy(busy2), .Rx_r_BR_Clocks(br_clk2), .o_dbg_state(dbg_state2)
  );

  always @(negedge clk) begin
    cyc++;
    if (rx_valid) begin
      got_q.push_back(rx_data);
      valid_cyc = cyc;
      n_valid++;
    end
    if (frame_err) n_ferr++;
    if (rx_valid && frame_err) n_both++;
    if (busy) busy_cyc++;
    if (rx_valid2) begin
      got2_q.push_back(rx_data2);
      n_valid2++;
    end
    if (frame_err2) n_ferr2++;
    if (rx_valid2 && frame_err2) n_both2++;
  end

  function automatic int exp_div(input int clk_hz, input int s);
    int baud;
    case (s)
      0: baud = 9600;
      1: baud = 19200;
      2: baud = 38400;
      3: baud = 57600;
      4: baud = 115200;
      5: baud = 230400;
      6: baud = 460800;
      default: baud = 921600;
    endcase
    return clk_hz / baud;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit lb, input logic v);
    if (lb) rx2 = v;
    else    rx  = v;
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop_hi, input int d, input bit lb);
    set_line(lb, 1'b0);
    tick(d);
    for (int i = 0; i < 8; i++) begin
      set_line(lb, b[i]);
      tick(d);
    end
    set_line(lb, stop_hi);
    tick(d);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    n_checks++; if (rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h exp 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_pulses: got %b%b exp 00", rx_valid, frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (br_clk !== 15'd0) begin n_errors++; $display("FAIL reset_br: got %0d exp 0", br_clk); end
    tick(1);
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_div_table();
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick(2);
      rx = 1'b0;
      tick(6);
      @(negedge clk);
      n_checks++;
      if (br_clk !== 15'(exp_div(100_000_000, s)) || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL div_sel%0d: got br=%0d busy=%b exp br=%0d busy=1", s, br_clk, busy, exp_div(100_000_000, s));
      end
      tick(1);
      rx = 1'b1;
      pulse_reset();
      tick(4);
    end
  endtask

  task automatic test_basic();
    int d, base, v0, start_cyc, lat;
    sel = 3'd7;
    d = exp_div(100_000_000, 7);
    tick(4);
    base = got_q.size();
    v0 = n_valid;
    exp_q.push_back(8'hA5);
    start_cyc = cyc + 1;
    drive_frame(8'hA5, 1'b1, d, 1'b0);
    tick(d);
    @(negedge clk);
    n_checks++; if (n_valid - v0 != 1) begin n_errors++; $display("FAIL basic_count: got %0d exp 1", n_valid - v0); end
    n_checks++; if (got_q[base] !== exp_q[0]) begin n_errors++; $display("FAIL basic_data: got %h exp %h", got_q[base], exp_q[0]); end
    n_checks++; if (rx_data !== 8'hA5) begin n_errors++; $display("FAIL basic_hold: got %h exp a5", rx_data); end
    n_checks++; if (br_clk !== 15'(d)) begin n_errors++; $display("FAIL basic_br: got %0d exp %0d", br_clk, d); end
    lat = valid_cyc - start_cyc;
    n_checks++;
    if (lat < 2 + d / 2 + 9 * d - 2 || lat > 2 + d / 2 + 9 * d + 2) begin
      n_errors++;
      $display("FAIL basic_latency: got %0d exp %0d+/-2", lat, 2 + d / 2 + 9 * d);
    end
    void'(exp_q.pop_front());
    last_good = 8'hA5;
    tick(1);
  endtask

  task automatic test_glitch();
    int v0, f0, b0, bc;
    sel = 3'd4;
    tick(4);
    v0 = n_valid; f0 = n_ferr; b0 = busy_cyc;
    rx = 1'b0;
    tick(200);
    rx = 1'b1;
    tick(1500);
    @(negedge clk);
    bc = busy_cyc - b0;
    n_checks++; if (n_valid != v0 || n_ferr != f0) begin n_errors++; $display("FAIL glitch_pulse: got valid+%0d ferr+%0d exp 0 0", n_valid - v0, n_ferr - f0); end
    n_checks++; if (bc < 430 || bc > 440) begin n_errors++; $display("FAIL glitch_busy_len: got %0d exp 430..440", bc); end
    n_checks++; if (busy !== 1'b0 || rx_data !== last_good) begin n_errors++; $display("FAIL glitch_idle: got busy=%b data=%h exp 0 %h", busy, rx_data, last_good); end
    tick(1);
  endtask

  task automatic test_frame_error();
    int d, v0, f0;
    sel = 3'd7;
    d = exp_div(100_000_000, 7);
    tick(4);
    v0 = n_valid; f0 = n_ferr;
    drive_frame(8'h3C, 1'b0, d, 1'b0);
    tick(500 - d);
    @(negedge clk);
    n_checks++; if (n_ferr - f0 != 1) begin n_errors++; $display("FAIL ferr_count: got %0d exp 1", n_ferr - f0); end
    n_checks++; if (n_valid != v0) begin n_errors++; $display("FAIL ferr_novalid: got %0d exp 0", n_valid - v0); end
    n_checks++; if (rx_data !== last_good) begin n_errors++; $display("FAIL ferr_data_kept: got %h exp %h", rx_data, last_good); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ferr_busy_low_line: got %b exp 1", busy); end
    tick(1);
    rx = 1'b1;
    tick(6);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ferr_busy_release: got %b exp 0", busy); end
    tick(1);
  endtask

  task automatic test_br_change();
    int d;
    logic [7:0] b;
    sel = 3'd7;
    d = exp_div(100_000_000, 7);
    b = 8'h81;
    tick(4);
    rx = 1'b0;
    tick(d);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) sel = 3'd0;
      rx = b[i];
      tick(d);
    end
    rx = 1'b1;
    tick(d);
    @(negedge clk);
    n_checks++; if (rx_data !== 8'h81) begin n_errors++; $display("FAIL brchg_data: got %h exp 81", rx_data); end
    n_checks++; if (br_clk !== 15'(d)) begin n_errors++; $display("FAIL brchg_br_held: got %0d exp %0d", br_clk, d); end
    last_good = 8'h81;
    tick(1);
    rx = 1'b0;
    tick(6);
    @(negedge clk);
    n_checks++; if (br_clk !== 15'(exp_div(100_000_000, 0))) begin n_errors++; $display("FAIL brchg_next_latch: got %0d exp %0d", br_clk, exp_div(100_000_000, 0)); end
    tick(1);
    rx = 1'b1;
    pulse_reset();
    last_good = 8'h00;
    sel = 3'd7;
    tick(4);
  endtask

  task automatic test_reset_midframe();
    int d, v0;
    d = exp_div(100_000_000, 7);
    sel = 3'd7;
    drive_frame(8'h81, 1'b1, d, 1'b0);
    tick(d);
    rx = 1'b0;
    tick(d);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      tick(d);
    end
    tick(d / 2);
    pulse_reset();
    @(negedge clk);
    n_checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 || br_clk !== 15'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got data=%h v=%b fe=%b busy=%b br=%0d exp all 0", rx_data, rx_valid, frame_err, busy, br_clk);
    end
    tick(1);
    v0 = n_valid;
    tick(6 * d);
    n_checks++; if (n_valid != v0) begin n_errors++; $display("FAIL midreset_no_spurious: got %0d exp 0", n_valid - v0); end
    drive_frame(8'h55, 1'b1, d, 1'b0);
    tick(d);
    @(negedge clk);
    n_checks++; if (rx_data !== 8'h55 || n_valid - v0 != 1) begin n_errors++; $display("FAIL midreset_next: got %h x%0d exp 55 x1", rx_data, n_valid - v0); end
    last_good = 8'h55;
    tick(1);
  endtask

  task automatic test_back_to_back();
    int d, base, f0, n;
    logic [7:0] b, e;
    sel = 3'd7;
    d = exp_div(100_000_000, 7);
    n = 6;
    base = got_q.size();
    f0 = n_ferr;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      drive_frame(b, 1'b1, d, 1'b0);
    end
    tick(d);
    n_checks++; if (got_q.size() - base != n) begin n_errors++; $display("FAIL b2b_count: got %0d exp %0d", got_q.size() - base, n); end
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q[base + i] !== e) begin n_errors++; $display("FAIL b2b_data%0d: got %h exp %h", i, got_q[base + i], e); end
      last_good = e;
    end
    n_checks++; if (n_ferr != f0 || n_both != 0) begin n_errors++; $display("FAIL b2b_errors: got ferr+%0d both=%0d exp 0 0", n_ferr - f0, n_both); end
  endtask

  task automatic test_loopback();
    int d, base, f0;
    logic [7:0] e;
    for (int s = 0; s < 8; s++) begin
      sel2 = 3'(s);
      d = exp_div(4_000_000, s);
      tick(4);
      base = got2_q.size();
      f0 = n_ferr2;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 4; i++) drive_frame(exp_q[i], 1'b1, d, 1'b1);
      tick(d);
      n_checks++; if (got2_q.size() - base != 4 || n_ferr2 != f0) begin n_errors++; $display("FAIL lb_sel%0d_count: got %0d ferr+%0d exp 4 0", s, got2_q.size() - base, n_ferr2 - f0); end
      n_checks++; if (br_clk2 !== 15'(d)) begin n_errors++; $display("FAIL lb_sel%0d_br: got %0d exp %0d", s, br_clk2, d); end
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (got2_q[base + i] !== e) begin n_errors++; $display("FAIL lb_sel%0d_data%0d: got %h exp %h", s, i, got2_q[base + i], e); end
      end
    end
    n_checks++; if (n_both2 != 0) begin n_errors++; $display("FAIL lb_both_pulses: got %0d exp 0", n_both2); end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx2 = 1'b1;
    sel = 3'd7;
    sel2 = 3'd0;
    last_good = 8'h00;
    tick(1);
    test_reset();
    test_div_table();
    test_basic();
    test_glitch();
    test_frame_error();
    test_br_change();
    test_reset_midframe();
    test_back_to_back();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
